// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: states, ALU ops, condition codes, mux selects.
// MC_CTRL_CMP_EN adds CMP/TST as flag-only data-processing commands.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    FAULT  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic       SRCA_REG      = 1'b0;
  localparam logic       SRCA_PC       = 1'b1;
  localparam logic [1:0] SRCB_WD       = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Flag-only commands; without the option they are never recognised.
  function automatic logic cmd_is_compare(input logic [3:0] cmd);
`ifdef MC_CTRL_CMP_EN
    return (cmd == CMD_CMP) || (cmd == CMD_TST);
`else
    return (cmd == 4'hF) && (cmd != 4'hF);
`endif
  endfunction

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || cmd_is_compare(cmd);
  endfunction

  function automatic logic [1:0] cmd_alu_op(input logic [3:0] cmd);
    logic [1:0] op;
    op = ALU_ADD;
    case (cmd)
      CMD_ADD:          op = ALU_ADD;
      CMD_SUB, CMD_CMP: op = ALU_SUB;
      CMD_AND, CMD_TST: op = ALU_AND;
      CMD_ORR:          op = ALU_ORR;
      default:          op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check against registered {N,Z,C,V}.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = !z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = !c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = !n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = !v;
      COND_HI: cond_ok = c && !z;
      COND_LS: cond_ok = !c || z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = !z && (n == v);
      COND_LE: cond_ok = z || (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: Moore FSM sequencing fetch/decode/execute with memory wait-state timeout and flag register.
// MC_CTRL_CMP_EN: CMP/TST update flags and return straight to FETCH.
module mc_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUCTL_W    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [19:0]         instr_hi,
  input  logic [3:0]          alu_flags,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [1:0]          imm_src,
  output logic [1:0]          reg_src,
  output logic [3:0]          flags,
  output logic                fault
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = instr_hi[19:16];
  assign op        = instr_hi[15:14];
  assign funct     = instr_hi[13:8];
  assign cmd       = funct[4:1];
  assign rd        = instr_hi[3:0];
  assign unused_rn = &{1'b0, instr_hi[7:4]};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [3:0]       flags_reg, flags_next;
  logic             cond_ok;
  logic             timeout;

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c, result_src_c, alu_op_c;

  cond_eval u_cond_eval (
    .cond    (cond),
    .flags   (flags_reg),
    .cond_ok (cond_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      flags_reg    <= 4'b0000;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      flags_reg    <= flags_next;
    end
  end

  // A ready in the timeout cycle still completes the access.
  assign timeout = (wait_cnt_reg == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  always_comb begin
    state_next   = state_reg;
    flags_next   = flags_reg;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = ADR_PC;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = SRCA_REG;
    alu_src_b_c  = SRCB_WD;
    result_src_c = RES_ALUOUT;
    alu_op_c     = ALU_ADD;

    case (state_reg)
      FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURESULT;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = FAULT;
        end
      end
      DECODE: begin
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURESULT;
        if (!cond_ok) begin
          state_next = FETCH;
        end else begin
          case (op)
            OP_MEM:  state_next = MEMADR;
            OP_DP:   state_next = !cmd_supported(cmd) ? FAULT : (funct[5] ? EXECI : EXECR);
            OP_BR:   state_next = BRANCH;
            default: state_next = FAULT;
          endcase
        end
      end
      MEMADR: begin
        alu_src_b_c = SRCB_IMM;
        state_next  = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req_c = 1'b1;
        adr_src_c = ADR_ALUOUT;
        if (mem_ready)    state_next = MEMWB;
        else if (timeout) state_next = FAULT;
      end
      MEMWR: begin
        mem_req_c   = 1'b1;
        adr_src_c   = ADR_ALUOUT;
        mem_write_c = 1'b1;
        if (mem_ready)    state_next = FETCH;
        else if (timeout) state_next = FAULT;
      end
      MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        pc_write_c   = (rd == 4'd15);
        state_next   = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_b_c = (state_reg == EXECI) ? SRCB_IMM : SRCB_WD;
        alu_op_c    = cmd_alu_op(cmd);
        if (funct[0] || cmd_is_compare(cmd)) begin
          flags_next[3:2] = alu_flags[3:2];
          if (alu_op_c == ALU_ADD || alu_op_c == ALU_SUB)
            flags_next[1:0] = alu_flags[1:0];
        end
        state_next = cmd_is_compare(cmd) ? FETCH : ALUWB;
      end
      ALUWB: begin
        result_src_c = RES_ALUOUT;
        pc_write_c   = (rd == 4'd15);
        reg_write_c  = (rd != 4'd15);
        state_next   = FETCH;
      end
      BRANCH: begin
        alu_src_b_c  = SRCB_IMM;
        result_src_c = RES_ALURESULT;
        pc_write_c   = 1'b1;
        state_next   = FETCH;
      end
      FAULT:   state_next = FAULT;
      default: state_next = FAULT;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_next != state_reg) || mem_ready)
      wait_cnt_next = '0;
    else if (mem_req_c)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Everything combinational is forced quiet while reset is held low.
  assign mem_req     = reset & mem_req_c;
  assign mem_write   = reset & mem_write_c;
  assign adr_src     = reset & adr_src_c;
  assign ir_write    = reset & ir_write_c;
  assign pc_write    = reset & pc_write_c;
  assign reg_write   = reset & reg_write_c;
  assign alu_src_a   = reset & alu_src_a_c;
  assign alu_src_b   = reset ? alu_src_b_c  : 2'b00;
  assign result_src  = reset ? result_src_c : 2'b00;
  assign alu_control = reset ? ALUCTL_W'(alu_op_c) : '0;

  assign imm_src = op;
  assign reg_src = {op == OP_MEM, op == OP_BR};

  assign flags = flags_reg;
  assign fault = (state_reg == FAULT);

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle controller for the 32-bit ARM-subset core (LDR/STR, ADD/SUB/AND/ORR, B).
- Parametrised successor to the single-cycle controller. It sequences each instruction over 3–5 cycles on a shared datapath.
- Adds a ready/valid memory handshake with wait states, a timeout fault, and an internal condition-flag register.
- Sits between the instruction register / flag outputs and the multicycle datapath, inside the next CPU top.

Parameters:
- ALUCTL_W, 2, width of alu_control.
- MEM_TIMEOUT, 15, maximum consecutive wait cycles on a memory access before FAULT (must be ≥1).
- CNT_W, 4, width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- instr_hi  in  20  Instr[31:12] = {cond[3:0], op[1:0], funct[5:0], rn[3:0], rd[3:0]}.
- alu_flags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- mem_ready  in  1  memory has completed the access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  store strobe; valid only when qualified by mem_req.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write, pc_write, reg_write  out  1 each  register enables.
- alu_src_a  out  1  0 = A, 1 = PC.
- alu_src_b  out  2  00 = WriteData, 01 = ExtImm, 10 = const 4.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_control  out  ALUCTL_W  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- imm_src, reg_src  out  2 each  same encoding as the single-cycle core.
- flags  out  4  registered {N,Z,C,V}.
- fault  out  1  sticky fault indicator.

Behaviour:
- Reset (reset == 0 at posedge):
  - state = FETCH, flags = 0, wait_cnt = 0, fault = 0.
  - All enables and strobes are 0 while reset is low.
  - A reset asserted mid-instruction abandons that instruction; the controller is in FETCH on the first cycle after release.
- Outputs are Moore, decoded from state. In addition, pc_write, reg_write and mem_write are qualified by mem_ready and the condition result where noted below.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- FETCH:
  - Outputs: mem_req = 1, adr_src = 0, alu_src_a = 1, alu_src_b = 10, result_src = 10.
  - On mem_ready: ir_write = 1, pc_write = 1, go to DECODE. Otherwise stay.
- DECODE:
  - Computes PC+4 for R15 reads (alu_src_a = 1, alu_src_b = 10).
  - Evaluates cond against the registered flags (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 = never).
  - Condition fails: return to FETCH.
  - Condition passes:
    - op = 01 → MEMADR.
    - op = 00 → EXECR if funct[5] = 0, EXECI if funct[5] = 1.
    - op = 10 → BRANCH.
    - op = 11 → FAULT.
    - Data-processing with an unsupported cmd → FAULT.
- MEMADR: alu_src_b = 01, ADD. Go to MEMRD if funct[0] = 1, MEMWR if funct[0] = 0.
- MEMRD: mem_req = 1, adr_src = 1. On mem_ready → MEMWB.
- MEMWR: mem_req = 1, adr_src = 1, mem_write = 1. On mem_ready → FETCH.
- MEMWB: result_src = 01, reg_write = 1, then FETCH. If rd = 15, also assert pc_write.
- EXECR / EXECI:
  - alu_src_b = 00 (EXECR) or 01 (EXECI).
  - alu_control is decoded from cmd = funct[4:1]: 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - If funct[0] (S) = 1, flags are updated at the end of the cycle:
    - N and Z always.
    - C and V only for ADD/SUB; otherwise C and V are held.
  - Next state: ALUWB.
- ALUWB: result_src = 00, reg_write = 1, then FETCH. If rd = 15, assert pc_write in place of reg_write.
- BRANCH: alu_src_b = 01, result_src = 10, pc_write = 1, then FETCH.
- Wait counter:
  - wait_cnt increments on each cycle in which mem_req = 1 and mem_ready = 0.
  - It clears on mem_ready or on a state change.
  - If wait_cnt == MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - A mem_ready arriving in that same cycle wins: no fault.
- FAULT: fault = 1, all enables 0. Held until reset.

Optional Feature:
- Macro MC_CTRL_CMP_EN.
- Defined:
  - cmd 1010 (CMP) executes as SUB; cmd 1000 (TST) executes as AND.
  - Flags update regardless of S.
  - ALUWB is skipped (EXEC → FETCH), so reg_write is never asserted.
- Undefined: CMP and TST are unsupported cmds and go to FAULT.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings (4-bit localparams, FETCH = 0);
  - ALU op codes;
  - cond codes;
  - mux-select encodings.
- Sub-module cond_eval: combinational; inputs cond[3:0] and flags[3:0], output cond_ok.

Test Plan:
1. Hold reset low 2 cycles, then ADD R1,R2,R3 (cond AL) with mem_ready tied 1 → states FETCH, DECODE, EXECR, ALUWB; reg_write = 1 only in cycle 4; back in FETCH in cycle 5.
2. LDR with mem_ready low for 3 cycles in MEMRD → mem_req held 3+1 cycles, adr_src = 1; MEMWB asserts reg_write = 1 with result_src = 01.
3. mem_ready stuck 0 in FETCH → fault = 1 after exactly 15 wait cycles and stays high; releasing mem_ready has no effect until reset is pulsed low.
4. ADDS giving alu_flags = 4'b0100 (Z = 1), then BEQ → BRANCH with pc_write = 1. Repeat with BNE → DECODE returns to FETCH; no pc_write after FETCH.
5. ANDS with alu_flags = 4'b1011 over prior flags 4'b0011 → flags = 4'b1011 for N/Z, C/V held at 11; a subsequent reset mid-MEMRD → FETCH next cycle, flags = 0.
6. CMP R1,R2 (cmd 1010):
   - With MC_CTRL_CMP_EN defined: flags updated, no reg_write, 3 cycles total.
   - Without MC_CTRL_CMP_EN: fault = 1 after DECODE.
